// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-side instruction fields, pipeline control and the
// register file write port with the retire counter.
interface mem_wb_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             mem_valid_i;
  logic [31:0]      mem_pc_i;
  logic [4:0]       mem_rd_addr_i;
  logic             mem_rd_wren_i;
  logic [1:0]       mem_wb_sel_i;
  logic [31:0]      mem_alu_data_i;
  logic [31:0]      mem_ld_data_i;
  logic [2:0]       mem_funct3_i;
  logic             stall_i;
  logic             flush_i;
  logic [4:0]       rd_addr_o;
  logic [31:0]      rd_data_o;
  logic             rd_wren_o;
  logic             wb_valid_o;
  logic [31:0]      wb_pc_o;
  logic [CNT_W-1:0] insn_retired_o;

  modport master (
    output mem_valid_i, mem_pc_i, mem_rd_addr_i, mem_rd_wren_i, mem_wb_sel_i,
    output mem_alu_data_i, mem_ld_data_i, mem_funct3_i, stall_i, flush_i,
    input  rd_addr_o, rd_data_o, rd_wren_o, wb_valid_o, wb_pc_o, insn_retired_o
  );

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_rd_addr_i, mem_rd_wren_i, mem_wb_sel_i,
    input  mem_alu_data_i, mem_ld_data_i, mem_funct3_i, stall_i, flush_i,
    output rd_addr_o, rd_data_o, rd_wren_o, wb_valid_o, wb_pc_o, insn_retired_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment/extension, writeback source select,
// register file write port and retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  mem_wb_if.slave  bus
);

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelPc4  = 2'b10;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_data;
  logic [31:0]      w_wb_data;
  logic             w_wren;

  logic             r_valid;
  logic             r_wren;
  logic [4:0]       r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_byte = bus.mem_ld_data_i[7:0];
    case (bus.mem_alu_data_i[1:0])
      2'd0:    w_byte = bus.mem_ld_data_i[7:0];
      2'd1:    w_byte = bus.mem_ld_data_i[15:8];
      2'd2:    w_byte = bus.mem_ld_data_i[23:16];
      default: w_byte = bus.mem_ld_data_i[31:24];
    endcase
    // Halfword offset bit 0 is ignored, so misaligned halves fold down.
    w_half = bus.mem_alu_data_i[1] ? bus.mem_ld_data_i[31:16] : bus.mem_ld_data_i[15:0];
  end

  always_comb begin
    w_ld_data = bus.mem_ld_data_i;
    case (bus.mem_funct3_i)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.mem_ld_data_i;
    endcase
  end

  always_comb begin
    w_wb_data = 32'd0;
    case (bus.mem_wb_sel_i)
      SelAlu:  w_wb_data = bus.mem_alu_data_i;
      SelLoad: w_wb_data = w_ld_data;
      SelPc4:  w_wb_data = bus.mem_pc_i + 32'd4;
      default: w_wb_data = 32'd0;
    endcase
  end

  assign w_wren = bus.mem_valid_i & bus.mem_rd_wren_i & (bus.mem_rd_addr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_pc    <= 32'd0;
      r_cnt   <= '0;
    end else if (bus.flush_i) begin
      r_valid <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_pc    <= 32'd0;
    end else if (!bus.stall_i) begin
      r_valid <= bus.mem_valid_i;
      r_wren  <= w_wren;
      r_addr  <= bus.mem_rd_addr_i;
      r_data  <= w_wb_data;
      r_pc    <= bus.mem_pc_i;
      if (bus.mem_valid_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.rd_addr_o      = r_addr;
  assign bus.rd_data_o      = r_data;
  assign bus.rd_wren_o      = r_wren;
  assign bus.wb_valid_o     = r_valid;
  assign bus.wb_pc_o        = r_pc;
  assign bus.insn_retired_o = r_cnt;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the forwarding RV32I core.
- Captures the MEM-stage result, aligns and extends load data, and selects the writeback source.
- Drives the register file write port (rd_addr/rd_data/rd_wren) from registered outputs.
- Exposes the registered writeback value for the forwarding unit and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter; the bench may reduce it to test wrap.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- mem_valid_i  in  1  MEM stage holds a real instruction (0 = bubble).
- mem_pc_i  in  32  PC of the MEM-stage instruction.
- mem_rd_addr_i  in  5  destination register index.
- mem_rd_wren_i  in  1  instruction writes rd.
- mem_wb_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- mem_alu_data_i  in  32  ALU result; also the load byte address.
- mem_ld_data_i  in  32  raw aligned word read from data memory.
- mem_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- stall_i  in  1  hold stage contents.
- flush_i  in  1  replace captured instruction with a bubble.
- rd_addr_o  out  5  register file write index.
- rd_data_o  out  32  register file write data and forwarding value.
- rd_wren_o  out  1  register file write enable.
- wb_valid_o  out  1  WB holds a real instruction.
- wb_pc_o  out  32  PC of the WB instruction (debug/trace).
- insn_retired_o  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: when rst_ni=0 at a rising edge, all outputs and internal flops clear to 0, including insn_retired_o. Reset takes priority over flush and stall. A reset during a stall discards the held instruction.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N. There is no combinational path from inputs to outputs.
- Update priority at each edge: reset, then flush, then stall, then capture.
  - Flush: wb_valid_o=0 and rd_wren_o=0. rd_addr_o, rd_data_o and wb_pc_o clear to 0.
  - Stall (no flush): all outputs hold their values. rd_wren_o stays asserted if it was asserted, so the register file rewrites identical data, which is harmless.
  - Capture: outputs load from the MEM inputs as described below.
- rd_wren_o is captured as mem_valid_i AND mem_rd_wren_i AND (mem_rd_addr_i != 0). Writes to x0 are never issued.
- rd_data_o is computed combinationally before the register:
  - wb_sel 00: mem_alu_data_i.
  - wb_sel 10: mem_pc_i + 4, modulo 2^32.
  - wb_sel 11: 0.
  - wb_sel 01: load extraction using offset = mem_alu_data_i[1:0]:
    - LB/LBU: byte at bits [8*offset+7 : 8*offset], sign-extended (LB) or zero-extended (LBU).
    - LH/LHU: halfword selected by offset[1] (bit 0 ignored, so misaligned offsets 1/3 behave as 0/2), sign- or zero-extended.
    - LW: full word; offset ignored.
    - Undefined funct3 values (011, 110, 111): full word.
- When a bubble is captured (mem_valid_i=0), wb_valid_o=0 and rd_wren_o=0. The data fields still load, but they are don't-care.
- insn_retired_o increments by 1 at every capture edge where mem_valid_i=1.
  - No increment on stall, flush or reset edges.
  - Wraps from all-ones to 0 with no saturation.
- Flush and stall both asserted: the flush wins and the counter does not increment.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with mem_valid_i=1 → all outputs 0, insn_retired_o=0. Release → first valid capture gives insn_retired_o=1.
- Load extraction: mem_ld_data_i=0x80F47F12, wb_sel=01, rd=5.
  - LB at addr 0x...03 → rd_data_o=0xFFFFFF80.
  - LBU at addr 0x...03 → rd_data_o=0x00000080.
  - LH at addr 0x...02 → rd_data_o=0xFFFF80F4.
  - LHU at addr 0x...00 → rd_data_o=0x00007F12.
  - LW at addr 0x...01 → rd_data_o=0x80F47F12.
- x0 and JAL: valid, wren=1, rd=0, wb_sel=00 → rd_wren_o=0, wb_valid_o=1, counter increments. Valid, rd=1, wb_sel=10, pc=0xFFFFFFFC → rd_data_o=0x00000000, rd_wren_o=1.
- Stall then flush:
  - Capture rd=7, data=0x1234, then assert stall_i for 3 cycles while inputs change → outputs stay at rd=7/0x1234, counter unchanged.
  - Assert stall_i and flush_i together → wb_valid_o=0, rd_wren_o=0, counter unchanged.
- Counter wrap (CNT_W=4): 16 consecutive valid captures → insn_retired_o goes 1..15 then 0. Interleaved bubbles do not advance it.
